signal_averager: RTL and testbench
==================================

SIGNAL_AVERAGER -- requirements
Module: signal_averager

Interface
REQ-001 Parameter LOG2_N, default 4, log2 of the samples per averaging block (N = 2^LOG2_N, legal range 1..8).
REQ-002 Parameter FIFO_DEPTH, default 4, input FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 avalonst_sink_valid  in  1  upstream sample valid.
REQ-007 avalonst_sink_data  in  32  upstream sample, unsigned.
REQ-008 avalonst_sink_ready  out  1  block can accept a sample this cycle.
REQ-009 avalonst_source_valid  out  1  average result valid.
REQ-010 avalonst_source_data  out  32  average result, unsigned.
REQ-011 avalonst_source_ready  in  1  downstream accepts the result.
REQ-012 block_count  out  16  number of results delivered.

Function
REQ-013 Sink handshake: a sample is accepted only in a cycle where sink_valid=1 and sink_ready=1; sink_data is ignored otherwise.
REQ-014 sink_ready SHALL be registered and equal to (FIFO occupancy < FIFO_DEPTH); there is no pass-through when the FIFO is full.
REQ-015 The FIFO SHALL be first-in first-out, allowing a push and a pop in the same cycle with occupancy unchanged.
REQ-016 A sample accepted at edge t SHALL be poppable no earlier than edge t+1.
REQ-017 The FSM SHALL have two states, ACCUM and OUTPUT, and reset to ACCUM.
REQ-018 ACCUM: while the FIFO is non-empty, pop one sample per cycle and add it to the accumulator (width 32+LOG2_N, no overflow possible); increment sample_idx.
REQ-019 When the Nth sample of a block is added, the FSM SHALL go to OUTPUT on the same edge, registering source_data = (accumulator + sample) >> LOG2_N (floor, truncating) and source_valid = 1.
REQ-020 OUTPUT: no FIFO pops occur; sink acceptance continues until the FIFO is full; source_valid and source_data SHALL hold stable until source_ready=1.
REQ-021 On an edge with source_valid=1 and source_ready=1: source_valid goes to 0, the accumulator and sample_idx clear, block_count increments, and the FSM returns to ACCUM; the next pop is at the following edge.
REQ-022 block_count SHALL wrap from 0xFFFF to 0x0000.
REQ-023 source_valid SHALL never depend combinationally on source_ready.
REQ-024 Samples SHALL never be dropped or duplicated; backpressure propagates solely via sink_ready.

Reset
REQ-025 While reset_n=0, all outputs and state SHALL be cleared asynchronously: source_valid=0, source_data=0, sink_ready=0, block_count=0, FIFO empty, accumulator=0, sample_idx=0, FSM=ACCUM.
REQ-026 sink_ready SHALL rise at the first clk edge after reset_n deasserts.
REQ-027 Reset mid-block or mid-OUTPUT SHALL discard the partial sums and the pending result; the first result after reset averages only post-reset samples.

Verification
REQ-028 Ramp: sink presents 0,1,2,... continuously with source_ready=1 (default parameters) -> results 7, 23, 39, in order; block_count = 1, 2, 3.
REQ-029 Max values: sixteen samples of 0xFFFFFFFF -> source_data = 0xFFFFFFFF (no overflow).
REQ-030 Backpressure: source_ready=0 after the first result with sink_valid held high -> exactly 4 more samples accepted, then sink_ready=0; on source_ready=1, all queued samples are consumed in order and the second result is 23.
REQ-031 Sparse input: sink_valid toggles every other cycle with values 0..15 -> single result 7, source_valid high for exactly one cycle with source_ready=1.
REQ-032 Reset mid-block: after 10 ramp samples, pulse reset_n low, then feed 16 samples of 100 -> result 100, block_count = 1.
REQ-033 Wrap: force 65,536 results -> block_count returns to 0x0000 and the next result makes it 0x0001.

Source files
------------

// File: rtl/signal_averager.sv
// Block averager: buffers unsigned 32-bit samples in a small FIFO and emits
// the floor mean of every 2**LOG2_N samples over a ready/valid source port.
module signal_averager #(
  parameter int LOG2_N     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        avalonst_sink_valid,
  input  logic [31:0] avalonst_sink_data,
  output logic        avalonst_sink_ready,
  output logic        avalonst_source_valid,
  output logic [31:0] avalonst_source_data,
  input  logic        avalonst_source_ready,
  output logic [15:0] block_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int ACCW = 32 + LOG2_N;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  state_t            state, state_next;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_next;
  logic [ACCW-1:0]   acc, sum_next;
  logic [LOG2_N-1:0] sample_idx;
  logic              push, pop, last, handshake;

  assign push      = avalonst_sink_valid & avalonst_sink_ready;
  assign pop       = (state == ACCUM) && (count != '0);
  assign last      = (sample_idx == '1);
  assign handshake = (state == OUTPUT) && avalonst_source_valid && avalonst_source_ready;
  assign sum_next  = acc + ACCW'(mem[rd_ptr]);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM:  if (pop && last) state_next = OUTPUT;
      OUTPUT: if (handshake)   state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ACCUM;
    else
      state <= state_next;
  end

  // Storage has no reset; validity is tracked entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= avalonst_sink_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      avalonst_sink_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count               <= count_next;
      avalonst_sink_ready <= (count_next < DEPTH_C);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc                   <= '0;
      sample_idx            <= '0;
      avalonst_source_valid <= 1'b0;
      avalonst_source_data  <= '0;
      block_count           <= '0;
    end else if (handshake) begin
      acc                   <= '0;
      sample_idx            <= '0;
      avalonst_source_valid <= 1'b0;
      block_count           <= block_count + 1'b1;
    end else if (pop) begin
      acc        <= sum_next;
      sample_idx <= sample_idx + 1'b1;
      if (last) begin
        avalonst_source_data  <= 32'(sum_next >> LOG2_N);
        avalonst_source_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_signal_averager.sv
// Scoreboard bench for signal_averager: a reference model averages every
// accepted sample and queues expected results; tasks compare delivered ones.
module tb_signal_averager;

  localparam int LOG2_N = 4;
  localparam int N      = 1 << LOG2_N;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sink_valid = 1'b0;
  logic [31:0] sink_data = '0;
  logic        sink_ready;
  logic        source_valid;
  logic [31:0] source_data;
  logic        source_ready = 1'b0;
  logic [15:0] block_count;

  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;
  int valid_cycles = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [63:0] msum = '0;
  int          mcnt = 0;

  signal_averager #(.LOG2_N(LOG2_N), .FIFO_DEPTH(4)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .avalonst_sink_valid   (sink_valid),
    .avalonst_sink_data    (sink_data),
    .avalonst_sink_ready   (sink_ready),
    .avalonst_source_valid (source_valid),
    .avalonst_source_data  (source_data),
    .avalonst_source_ready (source_ready),
    .block_count           (block_count)
  );

  always #5 clk = ~clk;

  // Reference model and output capture.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msum = '0;
      mcnt = 0;
      exp_q.delete();
      obs_q.delete();
    end else begin
      if (sink_valid && sink_ready) begin
        accepted++;
        msum = msum + 64'(sink_data);
        mcnt++;
        if (mcnt == N) begin
          exp_q.push_back(32'(msum >> LOG2_N));
          msum = '0;
          mcnt = 0;
        end
      end
      if (source_valid) valid_cycles++;
      if (source_valid && source_ready) obs_q.push_back(source_data);
    end
  end

  // want > 0: stop once that many results are captured; want == 0: stop when
  // the input queue drains; want < 0: run the full cycle count.
  task automatic run(input int max_cycles, input int want, input bit sparse);
    int last_acc;
    bit phase;
    last_acc = accepted;
    phase = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (accepted != last_acc) begin
        void'(in_q.pop_front());
        last_acc = accepted;
      end
      if (want == 0 && in_q.size() == 0) break;
      if (want > 0 && obs_q.size() >= want) break;
      sink_valid = (in_q.size() != 0) && (!sparse || phase);
      sink_data  = (in_q.size() != 0) ? in_q[0] : '0;
      phase = !phase;
    end
    sink_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sink_valid = 1'b0;
    source_ready = 1'b0;
    in_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({source_valid, source_data, sink_ready, block_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b data=%h ready=%0b count=%h, want all zero",
               source_valid, source_data, sink_ready, block_count);
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if (sink_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: got %0b want 0", sink_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (sink_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_first_edge: got %0b want 1", sink_ready);
    end
  endtask

  task automatic test_ramp();
    logic [31:0] got, want;
    apply_reset();
    source_ready = 1'b1;
    for (int i = 0; i < 48; i++) in_q.push_back(32'(i));
    run(300, 3, 1'b0);
    vectors++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      miscompares++;
      $display("FAIL ramp_count: got %0d results (%0d expected queued), want 3", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL ramp_data: got %0d want %0d", got, want);
      end
    end
    vectors++;
    if (block_count !== 16'd3) begin
      miscompares++;
      $display("FAIL ramp_block_count: got %0d want 3", block_count);
    end
  endtask

  task automatic test_max();
    logic [31:0] got, want;
    apply_reset();
    source_ready = 1'b1;
    for (int i = 0; i < N; i++) in_q.push_back(32'hFFFF_FFFF);
    run(200, 1, 1'b0);
    vectors++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL max_count: got %0d results, want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL max_data: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, want;
    int acc0;
    apply_reset();
    acc0 = accepted;
    source_ready = 1'b0;
    for (int i = 0; i < 64; i++) in_q.push_back(32'(i));
    run(40, -1, 1'b0);
    vectors++;
    if (accepted - acc0 != N + 4) begin
      miscompares++;
      $display("FAIL bp_accepted: got %0d samples, want %0d", accepted - acc0, N + 4);
    end
    vectors++;
    if (sink_ready !== 1'b0 || source_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stall: got ready=%0b valid=%0b, want ready=0 valid=1", sink_ready, source_valid);
    end
    vectors++;
    if (exp_q.size() == 0 || source_data !== exp_q[0]) begin
      miscompares++;
      $display("FAIL bp_hold_data: got %0d, want first expected result (queued %0d)", source_data, exp_q.size());
    end
    source_ready = 1'b1;
    run(200, 2, 1'b0);
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL bp_count: got %0d results, want 2", obs_q.size());
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL bp_data: got %0d want %0d", got, want);
      end
    end
  endtask

  task automatic test_sparse();
    logic [31:0] got, want;
    int v0;
    apply_reset();
    source_ready = 1'b1;
    v0 = valid_cycles;
    for (int i = 0; i < N; i++) in_q.push_back(32'(i));
    run(200, 1, 1'b1);
    run(6, -1, 1'b0);
    vectors++;
    if (valid_cycles - v0 != 1) begin
      miscompares++;
      $display("FAIL sparse_valid_cycles: got %0d want 1", valid_cycles - v0);
    end
    vectors++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL sparse_count: got %0d results, want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL sparse_data: got %0d want %0d", got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, want;
    apply_reset();
    source_ready = 1'b1;
    for (int i = 0; i < 10; i++) in_q.push_back(32'(i));
    run(100, 0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    in_q.delete();
    #2;
    vectors++;
    if ({source_valid, source_data, sink_ready, block_count} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got valid=%0b data=%h ready=%0b count=%h, want all zero",
               source_valid, source_data, sink_ready, block_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) in_q.push_back(32'd100);
    run(200, 1, 1'b0);
    vectors++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d results, want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL midreset_data: got %0d want %0d", got, want);
      end
    end
    vectors++;
    if (block_count !== 16'd1) begin
      miscompares++;
      $display("FAIL midreset_block_count: got %0d want 1", block_count);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want_cnt[2];
    want_cnt[0] = 16'h0000;
    want_cnt[1] = 16'h0001;
    apply_reset();
    source_ready = 1'b1;
    @(negedge clk);
    force dut.block_count = 16'hFFFF;
    @(negedge clk);
    release dut.block_count;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) in_q.push_back(32'(i * 3 + r));
      run(200, 1, 1'b0);
      vectors++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
        miscompares++;
        $display("FAIL wrap_count: got %0d results, want 1", obs_q.size());
      end else if (obs_q[0] !== exp_q[0]) begin
        miscompares++;
        $display("FAIL wrap_data: got %0d want %0d", obs_q[0], exp_q[0]);
      end
      obs_q.delete();
      exp_q.delete();
      vectors++;
      if (block_count !== want_cnt[r]) begin
        miscompares++;
        $display("FAIL wrap_block_count: got %h want %h", block_count, want_cnt[r]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_max();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
